button_conditioner: RTL and testbench



---
 rtl/button_pkg.sv | 16 +
 rtl/sync_2ff.sv | 22 ++
 rtl/button_conditioner.sv | 129 ++++++++++++
 tb/tb_button_conditioner.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and default timing constants for the front-panel button conditioner.
package button_pkg;

    // Debounce FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEFAULT_HOLD_CYCLES     = 50000000;
    localparam int unsigned DEFAULT_REPEAT_CYCLES   = 20000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, async active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Plain flop chain; nothing may sit between the two stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Front-panel select button conditioner: synchronise, debounce, one pulse per press.
// Optional auto-repeat while held is enabled by defining BUTTON_CONDITIONER_AUTOREPEAT_EN.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic select_pulse,
    output logic btn_level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject configurations the counters cannot represent sensibly.
    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("button_conditioner: DEBOUNCE/HOLD/REPEAT cycles must each be at least 2");
    end

    btn_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic            btn_sync;
    logic            repeat_fire_c;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (btn_sync)
    );

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam int unsigned TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 1);

    logic [TMR_W-1:0] timer;
    logic             repeating;

    assign repeat_fire_c = (state == PRESSED) && btn_sync &&
                           (timer == (repeating ? REPEAT_LAST : HOLD_LAST));

    // Hold/repeat timer: runs only while held in PRESSED, restarts from the hold delay on re-entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer     <= '0;
            repeating <= 1'b0;
        end else if ((state == PRESSED) && btn_sync) begin
            if (repeat_fire_c) begin
                timer     <= '0;
                repeating <= 1'b1;
            end else begin
                timer <= timer + TMR_W'(1);
            end
        end else begin
            timer     <= '0;
            repeating <= 1'b0;
        end
    end
`else
    assign repeat_fire_c = 1'b0;
`endif

    // Debounce FSM with registered pulse and level outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            select_pulse <= 1'b0;
            btn_level    <= 1'b0;
        end else begin
            select_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state        <= PRESSED;
                        cnt          <= '0;
                        select_pulse <= 1'b1;
                        btn_level    <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!btn_sync) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_W'(1);
                    end else if (repeat_fire_c) begin
                        select_pulse <= 1'b1;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back high is the same press continuing, not a new one.
                    if (btn_sync) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner against a window-based behavioural model.
module tb_button_conditioner;

    localparam int unsigned D = 4;
    localparam int unsigned H = 10;
    localparam int unsigned R = 3;

    logic clk;
    logic reset;
    logic btn_raw;
    logic select_pulse;
    logic btn_level;

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .select_pulse (select_pulse),
        .btn_level    (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Behavioural model: 2-edge pin delay, then a press/release is accepted once the last
    // D synchronised samples all disagree with the accepted level.
    logic m_s1, m_s2;
    logic win[$];
    logic level;
    logic exp_pulse;
    logic prev_sample;
    int   held;

    // Bookkeeping for directed segments and the downstream 2-bit counter.
    int       step_idx;
    int       pulses;
    int       first_pulse;
    logic [1:0] sel_cnt;
    logic [1:0] exp_seq[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        win.delete();
        level = 1'b0;
        exp_pulse = 1'b0;
        prev_sample = 1'b0;
        held = 0;
    endtask

    function automatic logic window_all(input logic v);
        if (win.size() != D) return 1'b0;
        foreach (win[i]) if (win[i] !== v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        logic sample;
        sample = m_s2;
        m_s2 = m_s1;
        m_s1 = btn_raw;
        win.push_back(sample);
        if (win.size() > D) void'(win.pop_front());
        exp_pulse = 1'b0;
        if (!level && window_all(1'b1)) begin
            level = 1'b1;
            exp_pulse = 1'b1;
            held = 0;
        end else if (level && window_all(1'b0)) begin
            level = 1'b0;
        end else if (level && sample) begin
            if (!prev_sample) begin
                held = 0;
            end else begin
                held++;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                if (held == H || (held > H && ((held - H) % R) == 0)) exp_pulse = 1'b1;
`endif
            end
        end
        prev_sample = sample;
    endtask

    task automatic seg_start();
        step_idx = 0;
        pulses = 0;
        first_pulse = -1;
    endtask

    // One clock: drive at the falling edge, model the rising edge, check at the next falling edge.
    task automatic step(input logic b);
        btn_raw = b;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("select_pulse", 32'(select_pulse), 32'(exp_pulse));
        check("btn_level", 32'(btn_level), 32'(level));
        if (select_pulse === 1'b1) begin
            pulses++;
            sel_cnt = sel_cnt + 2'd1;
            if (first_pulse < 0) first_pulse = step_idx;
        end
        step_idx++;
    endtask

    task automatic steps(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check("reset_pulse", 32'(select_pulse), 32'd0);
        check("reset_level", 32'(btn_level), 32'd0);
        repeat (2) @(negedge clk);
        check("reset_hold_pulse", 32'(select_pulse), 32'd0);
        check("reset_hold_level", 32'(btn_level), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        logic [4:0] bounce;
        int exp_n;
        checks = 0;
        failures = 0;
        sel_cnt = 2'd0;
        btn_raw = 1'b0;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();
        steps(1'b0, 3);

        // Clean press: pulse after edge D+1, then release.
        seg_start();
        steps(1'b1, 21);
        check("clean_first_pulse", 32'(first_pulse), 32'(D + 1));
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        exp_n = 3;
`else
        exp_n = 1;
`endif
        check("clean_pulse_count", 32'(pulses), 32'(exp_n));
        steps(1'b0, 10);
        check("clean_released", 32'(btn_level), 32'd0);

        // Bounce on press: one pulse D+1 edges after the last rising sample.
        seg_start();
        bounce = 5'b01101;
        for (int i = 0; i < 5; i++) step(bounce[i]);
        steps(1'b1, 10);
        check("bounce_first_pulse", 32'(first_pulse), 32'(5 + D + 1));
        check("bounce_pulse_count", 32'(pulses), 32'd1);

        // Release with short high glitches: level held, no extra pulses.
        seg_start();
        steps(1'b0, 2);
        steps(1'b1, 2);
        steps(1'b0, 2);
        steps(1'b1, 2);
        check("release_glitch_level", 32'(btn_level), 32'd1);
        steps(1'b0, 10);
        check("release_glitch_pulses", 32'(pulses), 32'd0);
        check("release_glitch_final", 32'(btn_level), 32'd0);

        // Reset mid PRESS_WAIT, pin still high afterwards: debounce restarts, one pulse.
        steps(1'b1, 4);
        do_reset();
        seg_start();
        steps(1'b1, 10);
        check("reset_mid_first_pulse", 32'(first_pulse), 32'(D + 1));
        check("reset_mid_pulse_count", 32'(pulses), 32'd1);
        steps(1'b0, 10);

        // Downstream 2-bit counter fed by select_pulse.
        sel_cnt = 2'd0;
        for (int p = 0; p < 5; p++) begin
            steps(1'b1, 8);
            steps(1'b0, 8);
            check("counter_seq", 32'(sel_cnt), 32'(exp_seq[p]));
        end

        // Long hold: auto-repeat pulses when enabled, otherwise only the acceptance pulse.
        seg_start();
        steps(1'b1, D + 2 + 30);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        exp_n = 8;
`else
        exp_n = 1;
`endif
        check("long_hold_pulses", 32'(pulses), 32'(exp_n));
        steps(1'b0, 10);

        // Randomised bouncy segments with occasional resets, checked every cycle by the model.
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 15) == 0) do_reset();
            steps(1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
        end
        steps(1'b0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
